// File: rtl/discrete_choice_scheduler_if.sv
// Handshake and size-table bundle between a requester and the
// discrete choice scheduler.
interface discrete_choice_scheduler_if #(
    parameter int VIW = 2,
    parameter int CW  = 2
);
    logic           in_start;
    logic [VIW-1:0] in_variable_index;
    logic [VIW-1:0] out_table_variable_index;
    logic [CW-1:0]  in_number_of_discrete_assignments;
    logic           out_busy;
    logic           out_valid;
    logic           in_ready;
    logic [VIW-1:0] out_variable_index;
    logic [CW-1:0]  out_choice_index;
    logic           out_fallback;

    modport master (
        output in_start,
        output in_variable_index,
        output in_number_of_discrete_assignments,
        output in_ready,
        input  out_table_variable_index,
        input  out_busy,
        input  out_valid,
        input  out_variable_index,
        input  out_choice_index,
        input  out_fallback
    );

    modport slave (
        input  in_start,
        input  in_variable_index,
        input  in_number_of_discrete_assignments,
        input  in_ready,
        output out_table_variable_index,
        output out_busy,
        output out_valid,
        output out_variable_index,
        output out_choice_index,
        output out_fallback
    );
endinterface

// File: rtl/discrete_choice_scheduler.sv
// One uniform draw in [0, max] for an "inside" constraint, by
// rejection sampling the low bits of a free-running Galois LFSR.
module discrete_choice_scheduler #(
    parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
    parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 2,
    parameter int LFSR_WIDTH                        = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = 16'hACE1,
    parameter int MAX_REJECTS                       = 8
) (
    input logic                        clk,
    input logic                        reset,
    discrete_choice_scheduler_if.slave bus
);
    localparam int VIW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int CW  = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
    localparam int RCW = (MAX_REJECTS > 1) ? $clog2(MAX_REJECTS) : 1;
    localparam logic [LFSR_WIDTH-1:0] LFSR_MASK =
        LFSR_WIDTH'(32'h0000_B400);
    localparam logic [LFSR_WIDTH-1:0] SEED_SAFE =
        (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DRAW   = 2'd2,
        VALID  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [VIW-1:0]        tbl_idx_q, var_q;
    logic [CW-1:0]         max_q, choice_q, cand;
    logic                  fb_q;
    logic [RCW-1:0]        rej_q;
    logic                  accept, give_up;
    logic                  take_req, in_lookup, in_draw, in_valid;

    assign cand    = lfsr_q[CW-1:0];
    assign accept  = (cand <= max_q);
    assign give_up = (rej_q == RCW'(MAX_REJECTS - 1));
    assign lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK)
                               : (lfsr_q >> 1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_start) state_d = LOOKUP;
            LOOKUP:  state_d = DRAW;
            DRAW:    if (accept || give_up) state_d = VALID;
            VALID:   if (bus.in_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        take_req  = 1'b0;
        in_lookup = 1'b0;
        in_draw   = 1'b0;
        in_valid  = 1'b0;
        unique case (state_q)
            IDLE:    take_req  = bus.in_start;
            LOOKUP:  in_lookup = 1'b1;
            DRAW:    in_draw   = 1'b1;
            VALID:   in_valid  = 1'b1;
            default: ;
        endcase
    end

    // The LFSR free-runs, so the candidate depends on request timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q    <= SEED_SAFE;
            tbl_idx_q <= '0;
            var_q     <= '0;
            max_q     <= '0;
            choice_q  <= '0;
            fb_q      <= 1'b0;
            rej_q     <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            if (take_req) begin
                tbl_idx_q <= bus.in_variable_index;
                var_q     <= bus.in_variable_index;
            end
            if (in_lookup) begin
                max_q <= bus.in_number_of_discrete_assignments;
                rej_q <= '0;
            end
            if (in_draw) begin
                if (accept) begin
                    choice_q <= cand;
                    fb_q     <= 1'b0;
                end else if (give_up) begin
                    choice_q <= '0;
                    fb_q     <= 1'b1;
                end else begin
                    rej_q <= rej_q + RCW'(1);
                end
            end
        end
    end

    assign bus.out_table_variable_index = tbl_idx_q;
    assign bus.out_variable_index       = var_q;
    assign bus.out_choice_index         = choice_q;
    assign bus.out_fallback             = fb_q;
    assign bus.out_valid                = in_valid;
    assign bus.out_busy                 = (state_q != IDLE);
endmodule
